rob_commit: RTL and testbench

- Retire stage sitting directly downstream of the ROB read port.
- Inspects the ROB head each cycle and pops completed, non-cancelled entries in order, presenting them as registered commit beats.
- On a head entry flagged exception or mispredict, it retires or traps that entry, pulses a ROB flush, then drains all cancelled entries before resuming.
- Also keeps a retired-instruction counter and a head-stall watchdog.

---
 rtl/rob_commit_pkg.sv | 15 +
 rtl/rob_commit_if.sv | 44 ++++
 rtl/rob_commit_watchdog.sv | 37 +++
 rtl/rob_commit.sv | 116 +++++++++++
 tb/tb_rob_commit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_commit_pkg.sv
// Shared types and payload field positions for the ROB retire stage.
package rob_commit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int EXC_BIT     = 0;
  localparam int MISPRED_BIT = 1;
  localparam int CAUSE_LSB   = 2;
  localparam int CAUSE_W     = 4;

endpackage

// File: rtl/rob_commit_if.sv
// ROB head read port plus commit/trap/status signals of the retire stage.
interface rob_commit_if
  import rob_commit_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int IDWIDTH = 8
);
  logic               rob_empty_i;
  logic               rob_rcomplete_i;
  logic               rob_rcancel_i;
  logic [IDWIDTH-1:0] rob_rtag_i;
  logic [DWIDTH-1:0]  rob_rdata_i;
  logic [IDWIDTH-1:0] rob_rentrynum_i;
  logic               rob_rden_o;
  logic               rob_flush_o;
  logic               commit_ready_i;
  logic               commit_valid_o;
  logic [IDWIDTH-1:0] commit_tag_o;
  logic [IDWIDTH-1:0] commit_entry_o;
  logic               trap_valid_o;
  logic [CAUSE_W-1:0] trap_cause_o;
  logic               redirect_o;
  logic               dispatch_stall_o;
  logic [63:0]        instret_o;
  logic               hang_o;

  // The retire stage itself.
  modport master (
    input  rob_empty_i, rob_rcomplete_i, rob_rcancel_i, rob_rtag_i,
           rob_rdata_i, rob_rentrynum_i, commit_ready_i,
    output rob_rden_o, rob_flush_o, commit_valid_o, commit_tag_o,
           commit_entry_o, trap_valid_o, trap_cause_o, redirect_o,
           dispatch_stall_o, instret_o, hang_o
  );

  // ROB plus architectural-state sink.
  modport slave (
    output rob_empty_i, rob_rcomplete_i, rob_rcancel_i, rob_rtag_i,
           rob_rdata_i, rob_rentrynum_i, commit_ready_i,
    input  rob_rden_o, rob_flush_o, commit_valid_o, commit_tag_o,
           commit_entry_o, trap_valid_o, trap_cause_o, redirect_o,
           dispatch_stall_o, instret_o, hang_o
  );
endinterface

// File: rtl/rob_commit_watchdog.sv
// Head-stall watchdog: saturating cycle counter with a sticky hang flag.
module rob_commit_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_run,
  input  logic i_empty,
  input  logic i_complete,
  input  logic i_pop,
  output logic o_hang
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_hang;

  // Counting only happens in RUN; FLUSH and DRAIN freeze the count.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cnt  <= '0;
      r_hang <= 1'b0;
    end else if (i_run) begin
      if (i_pop || i_empty) begin
        r_cnt <= '0;
      end else if (!i_complete && (r_cnt != LIMIT)) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LIMIT_M1) r_hang <= 1'b1;
      end
    end
  end

  assign o_hang = r_hang;

endmodule

// File: rtl/rob_commit.sv
// In-order retire stage: pops completed ROB heads, commits or traps them,
// and sequences the flush/drain of cancelled entries after a break.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int IDWIDTH = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  rob_commit_if.master  bus
);
  logic [DWIDTH-1:0]  w_payload;
  logic               w_unused_payload;
  logic               w_head_ok;
  logic               w_rden;
  logic               w_run;
  logic               w_hang;

  state_e             r_state;
  logic               r_commit_vld_p1;
  logic [IDWIDTH-1:0] r_commit_tag_p1;
  logic [IDWIDTH-1:0] r_commit_entry_p1;
  logic               r_trap_vld_p1;
  logic [CAUSE_W-1:0] r_trap_cause_p1;
  logic               r_redirect_p1;
  logic               r_flush_p1;
  logic [63:0]        r_instret;

  assign w_payload        = bus.rob_rdata_i;
  assign w_unused_payload = &{1'b0, w_payload};
  assign w_head_ok        = !bus.rob_empty_i & bus.rob_rcomplete_i & !bus.rob_rcancel_i;
  assign w_run            = (r_state == RUN);

  // The flush pulse trails the FLUSH state by a cycle; DRAIN waits it out so
  // no pop ever coincides with it and the ROB has marked its entries cancelled.
  always_comb begin
    w_rden = 1'b0;
    case (r_state)
      RUN:     w_rden = w_head_ok & bus.commit_ready_i;
      DRAIN:   w_rden = !r_flush_p1 & !bus.rob_empty_i & bus.rob_rcancel_i;
      default: w_rden = 1'b0;
    endcase
  end

  // ---- stage p0 -> p1: head decision to registered commit/trap beats ----
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state           <= RUN;
      r_commit_vld_p1   <= 1'b0;
      r_commit_tag_p1   <= '0;
      r_commit_entry_p1 <= '0;
      r_trap_vld_p1     <= 1'b0;
      r_trap_cause_p1   <= '0;
      r_redirect_p1     <= 1'b0;
      r_flush_p1        <= 1'b0;
      r_instret         <= '0;
    end else begin
      r_commit_vld_p1 <= 1'b0;
      r_trap_vld_p1   <= 1'b0;
      r_redirect_p1   <= 1'b0;
      r_flush_p1      <= (r_state == FLUSH);
      case (r_state)
        RUN: begin
          if (w_rden) begin
            if (w_payload[EXC_BIT]) begin
              r_trap_vld_p1   <= 1'b1;
              r_trap_cause_p1 <= w_payload[CAUSE_LSB +: CAUSE_W];
              r_state         <= FLUSH;
            end else begin
              r_commit_vld_p1   <= 1'b1;
              r_commit_tag_p1   <= bus.rob_rtag_i;
              r_commit_entry_p1 <= bus.rob_rentrynum_i;
              r_instret         <= r_instret + 64'd1;
              if (w_payload[MISPRED_BIT]) begin
                r_redirect_p1 <= 1'b1;
                r_state       <= FLUSH;
              end
            end
          end
        end
        FLUSH:   r_state <= DRAIN;
        DRAIN: begin
          if (!r_flush_p1 && (bus.rob_empty_i || !bus.rob_rcancel_i)) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  rob_commit_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk      (clk_i),
    .i_arst_n   (arst_n_i),
    .i_run      (w_run),
    .i_empty    (bus.rob_empty_i),
    .i_complete (bus.rob_rcomplete_i),
    .i_pop      (w_rden),
    .o_hang     (w_hang)
  );

  assign bus.rob_rden_o       = w_rden;
  assign bus.rob_flush_o      = r_flush_p1;
  assign bus.commit_valid_o   = r_commit_vld_p1;
  assign bus.commit_tag_o     = r_commit_tag_p1;
  assign bus.commit_entry_o   = r_commit_entry_p1;
  assign bus.trap_valid_o     = r_trap_vld_p1;
  assign bus.trap_cause_o     = r_trap_cause_p1;
  assign bus.redirect_o       = r_redirect_p1;
  assign bus.dispatch_stall_o = !w_run;
  assign bus.instret_o        = r_instret;
  assign bus.hang_o           = w_hang;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: a queue-based ROB drives the head, and an event-level
// model of retire/flush/drain predicts every cycle's outputs.
module tb_rob_commit;
  import rob_commit_pkg::*;

  localparam int TO = 4;

  typedef struct {
    bit         complete;
    bit         cancel;
    logic [7:0] tag;
    logic [7:0] data;
    logic [7:0] entry;
  } ent_t;

  typedef struct {
    bit         ready;
    bit         present;
    bit         complete;
    bit         cancel;
    logic [7:0] tag;
    bit         exp_rden;
    bit         exp_cv;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  rob_commit_if #(.DWIDTH(8), .IDWIDTH(8)) bus ();

  rob_commit #(.DWIDTH(8), .IDWIDTH(8), .TIMEOUT(TO)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        rq[$];
  bit          ready;
  int          m_brk;      // 0: retiring; n>0: n cycles after a trap/mispredict pop
  int          m_wd;
  bit          m_hang;
  logic [63:0] m_instret;
  bit          last_rden;
  int          next_entry = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(bit c, logic [7:0] tag, logic [7:0] data);
    ent_t e;
    e.complete = c;
    e.cancel   = 1'b0;
    e.tag      = tag;
    e.data     = data;
    e.entry    = 8'(next_entry);
    next_entry++;
    rq.push_back(e);
  endtask

  task automatic drive_head();
    if (rq.size() > 0) begin
      bus.rob_empty_i     = 1'b0;
      bus.rob_rcomplete_i = rq[0].complete;
      bus.rob_rcancel_i   = rq[0].cancel;
      bus.rob_rtag_i      = rq[0].tag;
      bus.rob_rdata_i     = rq[0].data;
      bus.rob_rentrynum_i = rq[0].entry;
    end else begin
      bus.rob_empty_i     = 1'b1;
      bus.rob_rcomplete_i = 1'b0;
      bus.rob_rcancel_i   = 1'b0;
      bus.rob_rtag_i      = '0;
      bus.rob_rdata_i     = '0;
      bus.rob_rentrynum_i = '0;
    end
    bus.commit_ready_i = ready;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc();
    ent_t        h;
    bit          present, e_rden, e_cv, e_tv, e_rd, e_fl, act_rden, flush_now;
    logic [7:0]  e_tag, e_ent;
    logic [3:0]  e_cause;
    present = (rq.size() > 0);
    if (present) h = rq[0];
    else h = '{default: '0};
    drive_head();
    #1;
    if (m_brk == 0)     e_rden = present && h.complete && !h.cancel && ready;
    else if (m_brk <= 2) e_rden = 1'b0;
    else                e_rden = present && h.cancel;
    chk("rden", 64'(bus.rob_rden_o), 64'(e_rden));
    chk("dispatch_stall", 64'(bus.dispatch_stall_o), 64'(m_brk != 0));
    e_cv = 0; e_tv = 0; e_rd = 0; e_fl = (m_brk == 1);
    e_tag = '0; e_ent = '0; e_cause = '0;
    if (m_brk == 0) begin
      if (e_rden || !present) m_wd = 0;
      else if (!h.complete && m_wd < TO) m_wd++;
      if (m_wd == TO) m_hang = 1'b1;
      if (e_rden) begin
        if (h.data[0]) begin
          e_tv = 1; e_cause = h.data[5:2]; m_brk = 1;
        end else begin
          e_cv = 1; e_tag = h.tag; e_ent = h.entry; m_instret++;
          if (h.data[1]) begin e_rd = 1; m_brk = 1; end
        end
      end
    end else if (m_brk < 3 || e_rden) begin
      m_brk++;
    end else begin
      m_brk = 0;
    end
    act_rden  = bus.rob_rden_o;
    flush_now = bus.rob_flush_o;
    last_rden = act_rden;
    @(posedge clk);
    if (act_rden && present) void'(rq.pop_front());
    if (flush_now) foreach (rq[i]) rq[i].cancel = 1'b1;
    #1;
    chk("commit_valid", 64'(bus.commit_valid_o), 64'(e_cv));
    if (e_cv) begin
      chk("commit_tag", 64'(bus.commit_tag_o), 64'(e_tag));
      chk("commit_entry", 64'(bus.commit_entry_o), 64'(e_ent));
    end
    chk("trap_valid", 64'(bus.trap_valid_o), 64'(e_tv));
    if (e_tv) chk("trap_cause", 64'(bus.trap_cause_o), 64'(e_cause));
    chk("redirect", 64'(bus.redirect_o), 64'(e_rd));
    chk("rob_flush", 64'(bus.rob_flush_o), 64'(e_fl));
    chk("instret", bus.instret_o, m_instret);
    chk("hang", 64'(bus.hang_o), 64'(m_hang));
    @(negedge clk);
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    arst_n = 1'b0;
    rq.delete();
    ready = 1'b0;
    drive_head();
    #1;
    chk("rst_commit_valid", 64'(bus.commit_valid_o), 64'd0);
    chk("rst_trap_valid", 64'(bus.trap_valid_o), 64'd0);
    chk("rst_redirect", 64'(bus.redirect_o), 64'd0);
    chk("rst_flush", 64'(bus.rob_flush_o), 64'd0);
    chk("rst_instret", bus.instret_o, 64'd0);
    chk("rst_hang", 64'(bus.hang_o), 64'd0);
    chk("rst_stall", 64'(bus.dispatch_stall_o), 64'd0);
    chk("rst_rden", 64'(bus.rob_rden_o), 64'd0);
    m_brk = 0; m_wd = 0; m_hang = 1'b0; m_instret = '0;
    #2 arst_n = 1'b1;
    @(negedge clk);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{ready:1, present:0, complete:0, cancel:0, tag:8'h00, exp_rden:0, exp_cv:0};
    tbl[1] = '{ready:1, present:1, complete:1, cancel:0, tag:8'h11, exp_rden:1, exp_cv:1};
    tbl[2] = '{ready:0, present:1, complete:1, cancel:0, tag:8'h12, exp_rden:0, exp_cv:0};
    tbl[3] = '{ready:1, present:1, complete:0, cancel:0, tag:8'h13, exp_rden:0, exp_cv:0};
    tbl[4] = '{ready:1, present:1, complete:1, cancel:1, tag:8'h14, exp_rden:0, exp_cv:0};
    tbl[5] = '{ready:1, present:1, complete:1, cancel:0, tag:8'h15, exp_rden:1, exp_cv:1};

    @(negedge clk);
    do_reset();

    // Three back-to-back completed heads.
    push(1, 8'd5, 8'h00); push(1, 8'd6, 8'h00); push(1, 8'd7, 8'h00);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("burst_rden", 64'(last_rden), 64'd1);
      chk("burst_tag", 64'(bus.commit_tag_o), 64'(5 + i));
    end
    cyc();
    chk("burst_instret", bus.instret_o, 64'd3);

    // Sink back-pressure: no pop, no watchdog count.
    push(1, 8'd9, 8'h00);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_no_rden", 64'(last_rden), 64'd0);
    end
    ready = 1'b1;
    cyc();
    chk("stall_commit_tag", 64'(bus.commit_tag_o), 64'd9);
    cyc();
    chk("stall_hang", 64'(bus.hang_o), 64'd0);
    chk("stall_instret", bus.instret_o, 64'd4);

    // Exception with cause B, then flush and drain of three younger entries.
    push(1, 8'h20, 8'h2D);
    push(1, 8'h21, 8'h00); push(1, 8'h22, 8'h00); push(1, 8'h23, 8'h00);
    cyc();
    chk("exc_trap_valid", 64'(bus.trap_valid_o), 64'd1);
    chk("exc_trap_cause", 64'(bus.trap_cause_o), 64'hB);
    chk("exc_instret", bus.instret_o, 64'd4);
    cyc();
    chk("exc_flush", 64'(bus.rob_flush_o), 64'd1);
    cyc();
    chk("exc_flush_rden", 64'(last_rden), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("drain_rden", 64'(last_rden), 64'd1);
      chk("drain_no_commit", 64'(bus.commit_valid_o), 64'd0);
    end
    cyc();
    cyc();
    chk("drain_done_stall", 64'(bus.dispatch_stall_o), 64'd0);

    // Mispredict: committed together with redirect, then flush/drain.
    push(1, 8'd2, 8'h02); push(1, 8'h30, 8'h00);
    cyc();
    chk("mp_commit_valid", 64'(bus.commit_valid_o), 64'd1);
    chk("mp_redirect", 64'(bus.redirect_o), 64'd1);
    chk("mp_tag", 64'(bus.commit_tag_o), 64'd2);
    chk("mp_instret", bus.instret_o, 64'd5);
    repeat (5) cyc();

    // Single-cycle head vectors from RUN.
    for (int r = 0; r < 6; r++) begin
      rq.delete();
      if (tbl[r].present) begin
        push(tbl[r].complete, tbl[r].tag, 8'h00);
        rq[0].cancel = tbl[r].cancel;
      end
      ready = tbl[r].ready;
      cyc();
      chk("tbl_rden", 64'(last_rden), 64'(tbl[r].exp_rden));
      chk("tbl_commit_valid", 64'(bus.commit_valid_o), 64'(tbl[r].exp_cv));
      if (tbl[r].exp_cv) chk("tbl_commit_tag", 64'(bus.commit_tag_o), 64'(tbl[r].tag));
    end
    rq.delete();

    // Randomised traffic; dispatch respects dispatch_stall_o.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!bus.dispatch_stall_o && rq.size() < 6 && $urandom_range(0, 2) == 0) begin
        logic [7:0] d;
        int         k;
        d = 8'($urandom);
        k = $urandom_range(0, 19);
        d[1:0] = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b00;
        push($urandom_range(0, 3) != 0, 8'($urandom), d);
      end
      if (rq.size() > 0 && !rq[0].complete && $urandom_range(0, 1) == 1) rq[0].complete = 1'b1;
      ready = ($urandom_range(0, 4) != 0);
      cyc();
    end

    // Watchdog: head incomplete for 6 cycles.
    do_reset();
    push(0, 8'h33, 8'h00);
    ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 3) chk("wd_not_yet", 64'(bus.hang_o), 64'd0);
      if (i == 4) chk("wd_hang_set", 64'(bus.hang_o), 64'd1);
    end
    rq[0].complete = 1'b1;
    cyc();
    cyc();
    chk("wd_hang_held", 64'(bus.hang_o), 64'd1);
    chk("wd_instret", bus.instret_o, 64'd1);

    // Asynchronous reset while draining.
    push(1, 8'h40, 8'h01);
    push(1, 8'h41, 8'h00); push(1, 8'h42, 8'h00); push(1, 8'h43, 8'h00);
    repeat (4) cyc();
    chk("mid_drain_stall", 64'(bus.dispatch_stall_o), 64'd1);
    do_reset();
    ready = 1'b1;
    push(1, 8'h44, 8'h00);
    cyc();
    cyc();
    chk("post_reset_instret", bus.instret_o, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
